// File: rtl/spi_master_core_pkg.sv
// Shared types and default sizing for the SPI mode-0 master.
package spi_master_core_pkg;

  localparam int unsigned SPI_DATA_W   = 8;
  localparam int unsigned SPI_CLK_HALF = 10;

  typedef enum logic [1:0] {
    StIdle,
    StShift,
    StHold,
    StGap
  } spi_state_e;

endpackage

// File: rtl/spi_master_core_if.sv
// User-side parallel handshake between a client and the SPI master core.
interface spi_master_core_if
  import spi_master_core_pkg::*;
#(
  parameter int unsigned DATA_W = SPI_DATA_W
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;
  logic [DATA_W-1:0] rx_data;
  logic              rx_valid;
  logic              busy;

  // Client side: issues frames and consumes received data.
  modport master (
    output tx_data, tx_valid,
    input  tx_ready, rx_data, rx_valid, busy
  );

  // Core side.
  modport slave (
    input  tx_data, tx_valid,
    output tx_ready, rx_data, rx_valid, busy
  );

endinterface

// File: rtl/spi_master_core_tick_gen.sv
// SCLK half-period divider: counts 0..CLK_HALF-1 while enabled, held at zero otherwise.
module spi_tick_gen #(
  parameter int unsigned CLK_HALF = 10
) (
  input  logic clk_100mhz,
  input  logic reset,
  input  logic en,
  output logic tick
);

  localparam int unsigned CntW = (CLK_HALF > 1) ? $clog2(CLK_HALF) : 1;
  localparam logic [CntW-1:0] CntLast = CntW'(CLK_HALF - 1);

  logic [CntW-1:0] cnt_q, cnt_d;

  // Next count: clear when disabled, wrap at the terminal value.
  always_comb begin
    cnt_d = cnt_q;
    if (!en) begin
      cnt_d = '0;
    end else if (cnt_q == CntLast) begin
      cnt_d = '0;
    end else begin
      cnt_d = cnt_q + CntW'(1);
    end
  end

  // Counter register.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign tick = en && (cnt_q == CntLast);

endmodule

// File: rtl/spi_master_core.sv
// SPI mode-0 master (CPOL=0, CPHA=0), MSB first, one frame per handshake, one slave select.
module spi_master_core
  import spi_master_core_pkg::*;
#(
  parameter int unsigned DATA_W   = SPI_DATA_W,
  parameter int unsigned CLK_HALF = SPI_CLK_HALF
) (
  input  logic                     clk_100mhz,
  input  logic                     reset,
  spi_master_core_if.slave         bus,
  output logic                     sclk,
  output logic                     mosi,
  input  logic                     miso,
  output logic                     cs_n
);

  localparam int unsigned BitW = $clog2(DATA_W) + 1;
  localparam logic [BitW-1:0] BitLast = BitW'(DATA_W - 1);

  spi_state_e        state_q, state_d;
  logic [DATA_W-1:0] tx_shift_q, tx_shift_d;
  logic [DATA_W-1:0] rx_shift_q, rx_shift_d;
  logic [DATA_W-1:0] rx_data_q, rx_data_d;
  logic [BitW-1:0]   bit_cnt_q, bit_cnt_d;
  logic              rx_valid_q, rx_valid_d;
  logic              tx_ready_q, tx_ready_d;
  logic              busy_q, busy_d;
  logic              sclk_q, sclk_d;
  logic              mosi_q, mosi_d;
  logic              cs_n_q, cs_n_d;
  logic              tick;

  // Divider runs only while a frame (including hold and gap) is in progress.
  spi_tick_gen #(
    .CLK_HALF (CLK_HALF)
  ) u_tick_gen (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .en         (state_q != StIdle),
    .tick       (tick)
  );

  // Frame sequencing, shift registers and pin next-state.
  always_comb begin
    state_d    = state_q;
    tx_shift_d = tx_shift_q;
    rx_shift_d = rx_shift_q;
    rx_data_d  = rx_data_q;
    bit_cnt_d  = bit_cnt_q;
    rx_valid_d = 1'b0;
    sclk_d     = sclk_q;
    mosi_d     = mosi_q;
    cs_n_d     = cs_n_q;

    unique case (state_q)
      StIdle: begin
        if (bus.tx_valid && tx_ready_q) begin
          tx_shift_d = bus.tx_data;
          mosi_d     = bus.tx_data[DATA_W-1];
          cs_n_d     = 1'b0;
          bit_cnt_d  = '0;
          state_d    = StShift;
        end
      end
      StShift: begin
        if (tick) begin
          sclk_d = ~sclk_q;
          if (!sclk_q) begin
            rx_shift_d = {rx_shift_q[DATA_W-2:0], miso};
          end else begin
            bit_cnt_d = bit_cnt_q + BitW'(1);
            if (bit_cnt_q != BitLast) begin
              tx_shift_d = tx_shift_q << 1;
              mosi_d     = tx_shift_q[DATA_W-2];
            end else begin
              state_d = StHold;
            end
          end
        end
      end
      StHold: begin
        if (tick) begin
          cs_n_d     = 1'b1;
          rx_data_d  = rx_shift_q;
          rx_valid_d = 1'b1;
          mosi_d     = 1'b0;
          state_d    = StGap;
        end
      end
      StGap: begin
        // Keeps cs_n high for at least one half-period before the next frame.
        if (tick) begin
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase

    tx_ready_d = (state_d == StIdle);
    busy_d     = (state_d != StIdle);
  end

  // State and registered outputs; reset aborts any frame in progress.
  always_ff @(posedge clk_100mhz) begin
    if (reset) begin
      state_q    <= StIdle;
      tx_shift_q <= '0;
      rx_shift_q <= '0;
      rx_data_q  <= '0;
      bit_cnt_q  <= '0;
      rx_valid_q <= 1'b0;
      tx_ready_q <= 1'b0;
      busy_q     <= 1'b0;
      sclk_q     <= 1'b0;
      mosi_q     <= 1'b0;
      cs_n_q     <= 1'b1;
    end else begin
      state_q    <= state_d;
      tx_shift_q <= tx_shift_d;
      rx_shift_q <= rx_shift_d;
      rx_data_q  <= rx_data_d;
      bit_cnt_q  <= bit_cnt_d;
      rx_valid_q <= rx_valid_d;
      tx_ready_q <= tx_ready_d;
      busy_q     <= busy_d;
      sclk_q     <= sclk_d;
      mosi_q     <= mosi_d;
      cs_n_q     <= cs_n_d;
    end
  end

  assign bus.tx_ready = tx_ready_q;
  assign bus.rx_data  = rx_data_q;
  assign bus.rx_valid = rx_valid_q;
  assign bus.busy     = busy_q;
  assign sclk         = sclk_q;
  assign mosi         = mosi_q;
  assign cs_n         = cs_n_q;

endmodule

// File: tb/tb_spi_master_core.sv
// Directed bench for the SPI mode-0 master with loopback, constant and slave-model miso sources.
module tb_spi_master_core;

  localparam int unsigned DW = 8;

  logic clk_100mhz = 1'b0;
  logic reset      = 1'b1;
  logic sclk, mosi, miso, cs_n;
  logic [1:0] mode = 2'd0;  // 0: loopback, 1: tied high, 2: slave model

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int e0    = 0;
  int lat;
  int gap;
  int rcnt;
  int rises_base;
  int rxv_base;
  logic [DW-1:0] got;

  spi_master_core_if #(.DATA_W(DW)) bus ();

  spi_master_core dut (
    .clk_100mhz (clk_100mhz),
    .reset      (reset),
    .bus        (bus),
    .sclk       (sclk),
    .mosi       (mosi),
    .miso       (miso),
    .cs_n       (cs_n)
  );

  always #5 clk_100mhz = ~clk_100mhz;

  always @(posedge clk_100mhz) cyc <= cyc + 1;

  // Count completed frames.
  int rxv_cnt = 0;
  always @(posedge clk_100mhz) if (bus.rx_valid) rxv_cnt <= rxv_cnt + 1;

  // sclk must never be high while the slave is deselected.
  int viol = 0;
  always @(negedge clk_100mhz) if (!reset && cs_n === 1'b1 && sclk !== 1'b0) viol++;

  // Observe the SPI bus from the slave's point of view.
  int        sclk_rises = 0;
  logic [DW-1:0] mosi_cap = '0;
  longint    t_prev = 0, t_last = 0;
  always @(posedge sclk) begin
    sclk_rises++;
    mosi_cap = {mosi_cap[DW-2:0], mosi};
    t_prev   = t_last;
    t_last   = $time;
  end

  // Slave model answering 0x3C, shifting on falling sclk.
  logic [DW-1:0] slv = '0;
  always @(negedge cs_n) slv = 8'h3C;
  always @(negedge sclk) if (!cs_n) slv = {slv[DW-2:0], 1'b0};

  assign miso = (mode == 2'd0) ? mosi : (mode == 2'd1) ? 1'b1 : slv[DW-1];

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Wait for IDLE, then hand one byte over; returns just after the handshake edge.
  task automatic start_frame(input logic [DW-1:0] d, input bit hold_valid);
    for (int i = 0; i < 300; i++) begin
      @(negedge clk_100mhz);
      if (bus.tx_ready) break;
    end
    check("ready_before_frame", 32'(bus.tx_ready), 32'd1);
    bus.tx_data  = d;
    bus.tx_valid = 1'b1;
    rises_base   = sclk_rises;
    @(posedge clk_100mhz);
    #1;
    e0 = cyc;
    if (!hold_valid) bus.tx_valid = 1'b0;
  endtask

  // Wait (bounded) for rx_valid; lat is cycles from handshake edge, -1 on timeout.
  task automatic wait_rx(output int l);
    l = -1;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_100mhz);
      if (bus.rx_valid) begin
        l = cyc - e0;
        break;
      end
    end
  endtask

  initial begin
    bus.tx_data  = '0;
    bus.tx_valid = 1'b0;

    // Reset state.
    repeat (3) @(negedge clk_100mhz);
    check("rst_tx_ready", 32'(bus.tx_ready), 32'd0);
    check("rst_busy", 32'(bus.busy), 32'd0);
    check("rst_cs_n", 32'(cs_n), 32'd1);
    check("rst_sclk", 32'(sclk), 32'd0);
    check("rst_mosi", 32'(mosi), 32'd0);
    check("rst_rx_data", 32'(bus.rx_data), 32'd0);
    check("rst_rx_valid", 32'(bus.rx_valid), 32'd0);
    reset = 1'b0;
    @(negedge clk_100mhz);
    check("ready_after_rst", 32'(bus.tx_ready), 32'd1);

    // 1: loopback 0xA5.
    mode = 2'd0;
    start_frame(8'hA5, 1'b0);
    #4;
    check("t1_cs_low", 32'(cs_n), 32'd0);
    check("t1_first_mosi", 32'(mosi), 32'd1);
    check("t1_busy", 32'(bus.busy), 32'd1);
    wait_rx(lat);
    check("t1_latency", 32'(lat), 32'd170);
    check("t1_rx_data", 32'(bus.rx_data), 32'hA5);
    check("t1_mosi_seq", 32'(mosi_cap), 32'hA5);
    @(negedge clk_100mhz);
    check("t1_rx_valid_pulse", 32'(bus.rx_valid), 32'd0);
    check("t1_rx_data_held", 32'(bus.rx_data), 32'hA5);

    // 2: miso tied high, send 0x00.
    mode = 2'd1;
    start_frame(8'h00, 1'b0);
    wait_rx(lat);
    check("t2_latency", 32'(lat), 32'd170);
    check("t2_rx_data", 32'(bus.rx_data), 32'hFF);
    check("t2_sclk_rises", 32'(sclk_rises - rises_base), 32'd8);
    check("t2_sclk_period", 32'(t_last - t_prev), 32'd200);
    check("t2_mosi_seq", 32'(mosi_cap), 32'h00);

    // 3: slave model returns 0x3C.
    mode = 2'd2;
    start_frame(8'h81, 1'b0);
    wait_rx(lat);
    check("t3_rx_data", 32'(bus.rx_data), 32'h3C);
    check("t3_cs_high", 32'(cs_n), 32'd1);
    check("t3_sclk_low", 32'(sclk), 32'd0);
    check("t3_mosi_seq", 32'(mosi_cap), 32'h81);

    // 4: tx_valid held high, 0x11 then 0x22 back to back.
    mode = 2'd0;
    start_frame(8'h11, 1'b1);
    bus.tx_data = 8'h22;
    wait_rx(lat);
    check("t4_lat_a", 32'(lat), 32'd170);
    check("t4_rx_a", 32'(bus.rx_data), 32'h11);
    gap = 1;
    for (int i = 0; i < 60; i++) begin
      @(negedge clk_100mhz);
      if (cs_n) gap++;
      else break;
    end
    bus.tx_valid = 1'b0;
    e0 = cyc;
    check("t4_cs_gap", 32'(gap), 32'd11);
    wait_rx(lat);
    check("t4_lat_b", 32'(lat), 32'd170);
    check("t4_rx_b", 32'(bus.rx_data), 32'h22);

    // 5: reset 60 cycles into a frame.
    start_frame(8'hC3, 1'b0);
    repeat (59) @(negedge clk_100mhz);
    check("t5_busy_before", 32'(bus.busy), 32'd1);
    rxv_base = rxv_cnt;
    reset = 1'b1;
    @(posedge clk_100mhz);
    #1;
    reset = 1'b0;
    @(negedge clk_100mhz);
    check("t5_cs_n", 32'(cs_n), 32'd1);
    check("t5_sclk", 32'(sclk), 32'd0);
    check("t5_busy", 32'(bus.busy), 32'd0);
    check("t5_rx_cleared", 32'(bus.rx_data), 32'd0);
    check("t5_ready_low", 32'(bus.tx_ready), 32'd0);
    @(negedge clk_100mhz);
    check("t5_ready_back", 32'(bus.tx_ready), 32'd1);
    repeat (200) @(negedge clk_100mhz);
    check("t5_no_rx_valid", 32'(rxv_cnt - rxv_base), 32'd0);
    start_frame(8'h5A, 1'b0);
    wait_rx(lat);
    check("t5_lat", 32'(lat), 32'd170);
    check("t5_rx_next", 32'(bus.rx_data), 32'h5A);

    // 6: tx_valid pulsed mid-frame with 0xFF is ignored.
    start_frame(8'h96, 1'b0);
    rcnt = 0;
    got  = '0;
    for (int i = 0; i < 400; i++) begin
      @(negedge clk_100mhz);
      if (bus.rx_valid) got = bus.rx_data;
      if (bus.tx_ready) break;
      rcnt++;
      if (i == 50) begin
        bus.tx_data  = 8'hFF;
        bus.tx_valid = 1'b1;
      end else begin
        bus.tx_valid = 1'b0;
      end
    end
    bus.tx_valid = 1'b0;
    check("t6_rx_data", 32'(got), 32'h96);
    check("t6_mosi_seq", 32'(mosi_cap), 32'h96);
    check("t6_ready_low_cycles", 32'(rcnt), 32'd180);
    repeat (5) @(negedge clk_100mhz);
    check("t6_no_extra_frame", 32'(bus.busy), 32'd0);

    check("frames_total", 32'(rxv_cnt), 32'd7);
    check("sclk_while_deselected", 32'(viol), 32'd0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
